difficulty_arbiter: RTL and testbench
=====================================

Name: difficulty_arbiter

Overview:
Parametrised successor to the fixed three-key difficulty select. It accepts N debounced level buttons and rising-edge detects them. A choice is held as pending until a separate confirm press commits it. The committed level is locked while a game is running. It sits between the key debouncers and the game-speed/scoring logic, and drives both a binary level index and a one-hot difficulty vector.

Parameters:
NUM_LEVELS, 3, number of level buttons/levels; index 0 = hardest (>=2)
DEFAULT_LEVEL, 2, level committed out of reset (< NUM_LEVELS); default = easiest
CONFIRM_TIMEOUT, 50000000, cycles a pending choice waits for confirm before discard (1 s at 50 MHz)
IDX_W, $clog2(NUM_LEVELS), derived localparam, width of level indices

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
btn_debounced  in  NUM_LEVELS  debounced level buttons, active-high; bit i selects level i
confirm_debounced  in  1  debounced confirm button, active-high
game_active  in  1  high while a game runs; freezes selection
level_idx  out  IDX_W  committed level, binary
difficulty  out  NUM_LEVELS  committed level, one-hot (1 << level_idx)
pending_idx  out  IDX_W  level awaiting confirm (valid only when pending_valid)
pending_valid  out  1  a choice is awaiting confirm
level_committed  out  1  one-cycle pulse on the cycle level_idx changes via commit
locked  out  1  high in LOCKED state

Behaviour:
- All outputs registered. Reset values: level_idx = DEFAULT_LEVEL; difficulty = 1 << DEFAULT_LEVEL; pending_idx = 0; pending_valid = 0; level_committed = 0; locked = 0. Reset also sets state = IDLE and timeout counter = 0.
- Edge detect: prev registers reset to all-ones. A button held through reset is not a press; it must be released and re-pressed. rise = in & ~prev, evaluated every cycle in every state.
- Priority among simultaneous rises: the lowest index (hardest) wins.
- IDLE:
  - game_active -> LOCKED.
  - else any btn rise -> PENDING, with pending_idx = winner and counter = 0.
  - confirm rise is ignored.
- PENDING: evaluated in this order each cycle.
  1. game_active -> LOCKED; pending discarded.
  2. confirm rise -> commit: level_idx and difficulty take pending_idx next cycle; level_committed pulses 1 cycle; -> IDLE. A btn rise in the same cycle is dropped.
  3. btn rise -> pending_idx = winner; counter = 0. Re-pressing the same button also restarts the counter.
  4. counter == CONFIRM_TIMEOUT-1 -> discard; -> IDLE; no pulse.
  5. else counter++.
- Committing the already-committed level still pulses level_committed.
- pending_valid = (state == PENDING).
- LOCKED: every btn and confirm rise is ignored; pending_valid = 0. game_active low -> IDLE next cycle. Presses made while locked do not carry over.
- Latency: an input edge sampled on cycle n is visible on the outputs at cycle n+1.
- Counter width: $clog2(CONFIRM_TIMEOUT)+1. It never wraps; it saturates by leaving PENDING.
- Reset asserted mid-PENDING or mid-LOCKED returns every register to its reset value immediately (asynchronous).
- Illegal parameters (DEFAULT_LEVEL >= NUM_LEVELS or NUM_LEVELS < 2) stop elaboration via a generate-time check.

Decomposition:
- Shared include difficulty_defs: state encodings IDLE = 2'd0, PENDING = 2'd1, LOCKED = 2'd2; default CONFIRM_TIMEOUT constant; level-index convention (0 = hardest).
- One sub-module, rise_detect. Parameter WIDTH; ports clk, reset, in, rise; prev reset to all-ones. Instantiated twice: once for the buttons (WIDTH = NUM_LEVELS) and once for confirm (WIDTH = 1).
- Priority encoder and FSM stay in difficulty_arbiter.

Test Plan (bench overrides CONFIRM_TIMEOUT = 8; NUM_LEVELS = 3; DEFAULT_LEVEL = 2):
1. Hold btn = 3'b001 through reset, then release -> pending_valid stays 0; level_idx = 2; difficulty = 3'b100. Re-press btn[0] -> pending_valid = 1, pending_idx = 0.
2. Press btn[1]; confirm rise 3 cycles later -> next cycle level_idx = 1, difficulty = 3'b010; level_committed high exactly 1 cycle; pending_valid = 0.
3. Simultaneous rise btn = 3'b101 in IDLE -> pending_idx = 0. Then btn[2] rise while PENDING -> pending_idx = 2, counter restarts (timeout 8 cycles after the second press).
4. Press btn[0], no confirm -> pending_valid falls 8 cycles after entry; level_idx unchanged; no level_committed pulse.
5. PENDING on level 1, raise game_active -> locked = 1, pending_valid = 0. Btn and confirm presses ignored while locked. Drop game_active -> locked = 0, level_idx unchanged, still no pending.
6. Commit level 0, enter PENDING on level 1, assert reset mid-PENDING -> level_idx = 2, difficulty = 3'b100, all other outputs at reset values within the same cycle.
7. Same-cycle confirm rise and btn[2] rise while pending level 1 -> commits level 1; btn[2] dropped; state IDLE.

Source files
------------

// File: rtl/difficulty_arbiter_pkg.sv
// Shared definitions for the difficulty arbiter: FSM state encodings, the
// default confirm window, and the level-index convention (0 = hardest).
package difficulty_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_CONFIRM_TIMEOUT = 50000000;
  localparam int unsigned HARDEST_LEVEL           = 0;

endpackage

// File: rtl/difficulty_arbiter_rise_detect.sv
// Per-bit rising-edge detector. History resets to all-ones so an input held
// through reset is not reported as a press until it is released and re-pressed.
module rise_detect #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] prev_d;

  // next history value and edge decode
  always_comb begin
    prev_d = in;
    rise   = in & ~prev_q;
  end

  // input history register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_q <= '1;
    else       prev_q <= prev_d;
  end

endmodule

// File: rtl/difficulty_arbiter.sv
// Difficulty select: edge-detected level buttons stage a pending choice that a
// confirm press commits; the committed level is frozen while a game runs.
module difficulty_arbiter
  import difficulty_arbiter_pkg::*;
#(
  parameter  int NUM_LEVELS      = 3,
  parameter  int DEFAULT_LEVEL   = 2,
  parameter  int CONFIRM_TIMEOUT = DEFAULT_CONFIRM_TIMEOUT,
  localparam int IDX_W           = $clog2(NUM_LEVELS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_LEVELS-1:0] btn_debounced,
  input  logic                  confirm_debounced,
  input  logic                  game_active,
  output logic [IDX_W-1:0]      level_idx,
  output logic [NUM_LEVELS-1:0] difficulty,
  output logic [IDX_W-1:0]      pending_idx,
  output logic                  pending_valid,
  output logic                  level_committed,
  output logic                  locked
);

  localparam int CNT_W = $clog2(CONFIRM_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONFIRM_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] DEF_IDX  = IDX_W'(DEFAULT_LEVEL);
  localparam logic [NUM_LEVELS-1:0] ONE_HOT_0 = {{(NUM_LEVELS-1){1'b0}}, 1'b1};

  if (NUM_LEVELS < 2 || DEFAULT_LEVEL >= NUM_LEVELS) begin : g_bad_params
    $error("difficulty_arbiter: illegal NUM_LEVELS/DEFAULT_LEVEL");
  end

  logic [NUM_LEVELS-1:0] btn_rise_s;
  logic                  conf_rise_s;
  logic                  any_rise_s;
  logic [IDX_W-1:0]      winner_s;
  logic                  commit_s;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      pend_q, pend_d;
  logic [IDX_W-1:0]      level_q, level_d;
  logic [NUM_LEVELS-1:0] diff_q, diff_d;
  logic                  pvalid_q, pvalid_d;
  logic                  commit_q, commit_d;
  logic                  locked_q, locked_d;

  rise_detect #(.WIDTH(NUM_LEVELS)) u_btn_rise (
    .clk(clk), .reset(reset), .in(btn_debounced), .rise(btn_rise_s)
  );

  rise_detect #(.WIDTH(1)) u_conf_rise (
    .clk(clk), .reset(reset), .in(confirm_debounced), .rise(conf_rise_s)
  );

  // priority encoder: scanning downward lets the lowest (hardest) index win
  always_comb begin
    any_rise_s = |btn_rise_s;
    winner_s   = '0;
    for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
      if (btn_rise_s[i]) winner_s = IDX_W'(i);
      else               winner_s = winner_s;
    end
  end

  // next-state logic, including pending choice and confirm-window counter
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    commit_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (game_active) begin
          state_d = LOCKED;
        end else if (any_rise_s) begin
          state_d = PENDING;
          pend_d  = winner_s;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      PENDING: begin
        if (game_active) begin
          state_d = LOCKED;
          cnt_d   = '0;
        end else if (conf_rise_s) begin
          state_d  = IDLE;
          commit_s = 1'b1;
          cnt_d    = '0;
        end else if (any_rise_s) begin
          pend_d = winner_s;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LOCKED: begin
        if (game_active) state_d = LOCKED;
        else             state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // registered-output next values
  always_comb begin
    level_d  = commit_s ? pend_q : level_q;
    diff_d   = ONE_HOT_0 << level_d;
    commit_d = commit_s;
    pvalid_d = (state_d == PENDING);
    locked_d = (state_d == LOCKED);
  end

  // state and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pend_q   <= '0;
      level_q  <= DEF_IDX;
      diff_q   <= ONE_HOT_0 << DEF_IDX;
      pvalid_q <= 1'b0;
      commit_q <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      level_q  <= level_d;
      diff_q   <= diff_d;
      pvalid_q <= pvalid_d;
      commit_q <= commit_d;
      locked_q <= locked_d;
    end
  end

  assign level_idx       = level_q;
  assign difficulty      = diff_q;
  assign pending_idx     = pend_q;
  assign pending_valid   = pvalid_q;
  assign level_committed = commit_q;
  assign locked          = locked_q;

endmodule

// File: tb/tb_difficulty_arbiter.sv
// Directed bench for difficulty_arbiter with a short confirm window (8 cycles).
module tb_difficulty_arbiter;

  logic       clk;
  logic       reset;
  logic [2:0] btn;
  logic       confirm;
  logic       game_active;
  logic [1:0] level_idx;
  logic [2:0] difficulty;
  logic [1:0] pending_idx;
  logic       pending_valid;
  logic       level_committed;
  logic       locked;

  int n_cmp = 0;
  int n_err = 0;

  difficulty_arbiter #(
    .NUM_LEVELS(3), .DEFAULT_LEVEL(2), .CONFIRM_TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset), .btn_debounced(btn), .confirm_debounced(confirm),
    .game_active(game_active), .level_idx(level_idx), .difficulty(difficulty),
    .pending_idx(pending_idx), .pending_valid(pending_valid),
    .level_committed(level_committed), .locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // inputs change on the falling edge; outputs are sampled there too
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; btn = 3'b001; confirm = 1'b0; game_active = 1'b0;
    tick(); tick(); #1;
    n_cmp++; if (level_idx !== 2'd2) begin n_err++; $display("FAIL rst_level got %0d want 2", level_idx); end
    n_cmp++; if (difficulty !== 3'b100) begin n_err++; $display("FAIL rst_diff got %b want 100", difficulty); end
    n_cmp++; if (pending_valid !== 1'b0 || pending_idx !== 2'd0) begin n_err++; $display("FAIL rst_pending got %b/%0d want 0/0", pending_valid, pending_idx); end
    n_cmp++; if (level_committed !== 1'b0 || locked !== 1'b0) begin n_err++; $display("FAIL rst_flags got %b%b want 00", level_committed, locked); end
    tick(); reset = 1'b0;
    tick();
    n_cmp++; if (pending_valid !== 1'b0) begin n_err++; $display("FAIL held_btn got %b want 0", pending_valid); end
    btn = 3'b000; tick();
    n_cmp++; if (pending_valid !== 1'b0 || level_idx !== 2'd2) begin n_err++; $display("FAIL release got %b/%0d want 0/2", pending_valid, level_idx); end
    btn = 3'b001; tick();
    n_cmp++; if (pending_valid !== 1'b1 || pending_idx !== 2'd0) begin n_err++; $display("FAIL repress got %b/%0d want 1/0", pending_valid, pending_idx); end
    btn = 3'b000;
    repeat (10) tick();
    n_cmp++; if (pending_valid !== 1'b0 || level_idx !== 2'd2) begin n_err++; $display("FAIL t1_expire got %b/%0d want 0/2", pending_valid, level_idx); end
  endtask

  task automatic test_commit();
    btn = 3'b010; tick();
    n_cmp++; if (pending_valid !== 1'b1 || pending_idx !== 2'd1) begin n_err++; $display("FAIL c_pend got %b/%0d want 1/1", pending_valid, pending_idx); end
    btn = 3'b000; tick(); tick();
    confirm = 1'b1; tick();
    n_cmp++; if (level_idx !== 2'd1 || difficulty !== 3'b010) begin n_err++; $display("FAIL c_level got %0d/%b want 1/010", level_idx, difficulty); end
    n_cmp++; if (level_committed !== 1'b1 || pending_valid !== 1'b0) begin n_err++; $display("FAIL c_pulse got %b/%b want 1/0", level_committed, pending_valid); end
    confirm = 1'b0; tick();
    n_cmp++; if (level_committed !== 1'b0 || level_idx !== 2'd1) begin n_err++; $display("FAIL c_pulse_end got %b/%0d want 0/1", level_committed, level_idx); end
  endtask

  task automatic test_priority();
    btn = 3'b101; tick();
    n_cmp++; if (pending_idx !== 2'd0 || pending_valid !== 1'b1) begin n_err++; $display("FAIL prio got %0d/%b want 0/1", pending_idx, pending_valid); end
    btn = 3'b000; tick();
    btn = 3'b100; tick();
    n_cmp++; if (pending_idx !== 2'd2) begin n_err++; $display("FAIL repend got %0d want 2", pending_idx); end
    btn = 3'b000;
    repeat (7) tick();
    n_cmp++; if (pending_valid !== 1'b1) begin n_err++; $display("FAIL restart_hold got %b want 1", pending_valid); end
    tick();
    n_cmp++; if (pending_valid !== 1'b0 || level_idx !== 2'd1) begin n_err++; $display("FAIL restart_expire got %b/%0d want 0/1", pending_valid, level_idx); end
  endtask

  task automatic test_timeout();
    btn = 3'b001; tick();
    n_cmp++; if (pending_valid !== 1'b1 || pending_idx !== 2'd0) begin n_err++; $display("FAIL to_pend got %b/%0d want 1/0", pending_valid, pending_idx); end
    btn = 3'b000;
    for (int i = 1; i < 8; i++) begin
      tick();
      n_cmp++; if (pending_valid !== 1'b1 || level_committed !== 1'b0) begin n_err++; $display("FAIL to_wait[%0d] got %b/%b want 1/0", i, pending_valid, level_committed); end
    end
    tick();
    n_cmp++; if (pending_valid !== 1'b0 || level_idx !== 2'd1 || level_committed !== 1'b0) begin n_err++; $display("FAIL to_expire got %b/%0d/%b want 0/1/0", pending_valid, level_idx, level_committed); end
  endtask

  task automatic test_lock();
    btn = 3'b010; tick();
    btn = 3'b000; tick();
    game_active = 1'b1; tick();
    n_cmp++; if (locked !== 1'b1 || pending_valid !== 1'b0) begin n_err++; $display("FAIL lock_enter got %b/%b want 1/0", locked, pending_valid); end
    btn = 3'b001; tick();
    btn = 3'b000; confirm = 1'b1; tick();
    confirm = 1'b0; btn = 3'b100; tick();
    n_cmp++; if (locked !== 1'b1 || pending_valid !== 1'b0 || level_idx !== 2'd1 || level_committed !== 1'b0) begin n_err++; $display("FAIL lock_ignore got %b/%b/%0d/%b want 1/0/1/0", locked, pending_valid, level_idx, level_committed); end
    game_active = 1'b0; tick();
    n_cmp++; if (locked !== 1'b0 || pending_valid !== 1'b0 || level_idx !== 2'd1) begin n_err++; $display("FAIL unlock got %b/%b/%0d want 0/0/1", locked, pending_valid, level_idx); end
    tick();
    n_cmp++; if (pending_valid !== 1'b0) begin n_err++; $display("FAIL no_carry got %b want 0", pending_valid); end
    btn = 3'b000; tick();
  endtask

  task automatic test_async_reset();
    btn = 3'b001; tick();
    btn = 3'b000; confirm = 1'b1; tick();
    n_cmp++; if (level_idx !== 2'd0 || difficulty !== 3'b001) begin n_err++; $display("FAIL ar_commit got %0d/%b want 0/001", level_idx, difficulty); end
    confirm = 1'b0; btn = 3'b010; tick();
    n_cmp++; if (pending_valid !== 1'b1 || pending_idx !== 2'd1) begin n_err++; $display("FAIL ar_pend got %b/%0d want 1/1", pending_valid, pending_idx); end
    btn = 3'b000; tick();
    reset = 1'b1; #1;
    n_cmp++; if (level_idx !== 2'd2 || difficulty !== 3'b100) begin n_err++; $display("FAIL ar_level got %0d/%b want 2/100", level_idx, difficulty); end
    n_cmp++; if (pending_valid !== 1'b0 || pending_idx !== 2'd0 || level_committed !== 1'b0 || locked !== 1'b0) begin n_err++; $display("FAIL ar_rest got %b/%0d/%b/%b want 0/0/0/0", pending_valid, pending_idx, level_committed, locked); end
    tick(); reset = 1'b0; tick();
  endtask

  task automatic test_same_cycle();
    btn = 3'b010; tick();
    btn = 3'b000; tick();
    confirm = 1'b1; btn = 3'b100; tick();
    n_cmp++; if (level_idx !== 2'd1 || difficulty !== 3'b010 || level_committed !== 1'b1) begin n_err++; $display("FAIL sc_commit got %0d/%b/%b want 1/010/1", level_idx, difficulty, level_committed); end
    confirm = 1'b0; btn = 3'b000; tick();
    n_cmp++; if (pending_valid !== 1'b0 || level_idx !== 2'd1) begin n_err++; $display("FAIL sc_drop got %b/%0d want 0/1", pending_valid, level_idx); end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_priority();
    test_timeout();
    test_lock();
    test_async_reset();
    test_same_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
